interleaver_read_scheduler: RTL and testbench
=============================================

INTERLEAVER_READ_SCHEDULER -- requirements
Module: interleaver_read_scheduler

Interface
REQ-001 SHALL have parameter ROW_NUMBER, default 10, interleaver matrix rows.
REQ-002 SHALL have parameter COL_NUMBER, default 7, interleaver matrix columns; N = ROW_NUMBER*COL_NUMBER, AW = $clog2(N).
REQ-003 SHALL have port CLK  input  1  clock, all logic on rising edge.
REQ-004 SHALL have port RESET  input  1  synchronous, active-high reset.
REQ-005 SHALL have port READ_START  input  1  writer frame-ready request, held high until READ_ACK seen.
REQ-006 SHALL have port READ_ACK  output  1  one-cycle grant pulse to the writer.
REQ-007 SHALL have port PING_PONG_FLAG  input  1  bank the writer has just filled.
REQ-008 SHALL have port BUFF_RD_ADDR  output  AW+1  buffer read address, MSB = bank, LSBs = linear index.
REQ-009 SHALL have port BUFF_RD_EN  output  1  buffer read strobe.
REQ-010 SHALL have port BUFF_RD_DATA  input  1  buffer read data, valid the cycle after BUFF_RD_EN.
REQ-011 SHALL have port FIFO_OUT_DATA  output  1  interleaved bit to output FIFO.
REQ-012 SHALL have port FIFO_OUT_WE  output  1  output FIFO write strobe.
REQ-013 SHALL have port FIFO_OUT_FULL  input  1  output FIFO full.
REQ-014 SHALL have port BUSY  output  1  high in every state except IDLE.
REQ-015 SHALL have port FRAME_DONE  output  1  one-cycle pulse after the last bit of a frame is written.

Function
REQ-016 SHALL implement FSM states IDLE, ACK, WAIT_SPACE, RD_REQ, RD_CAPTURE, WR_FIFO, DONE; any other encoding -> IDLE next cycle.
REQ-017 IDLE: READ_START=1 -> latch Bank_Reg = PING_PONG_FLAG, clear Index to 0, go ACK; else stay.
REQ-018 ACK: READ_ACK=1 for exactly this cycle; next state WAIT_SPACE unconditionally.
REQ-019 WAIT_SPACE: FIFO_OUT_FULL=0 -> RD_REQ; FIFO_OUT_FULL=1 -> stay, no strobes asserted.
REQ-020 RD_REQ: BUFF_RD_EN=1, BUFF_RD_ADDR={Bank_Reg, Index}; next RD_CAPTURE.
REQ-021 RD_CAPTURE: register BUFF_RD_DATA into Data_Reg; next WR_FIFO.
REQ-022 WR_FIFO: FIFO_OUT_WE=1, FIFO_OUT_DATA=Data_Reg; Index==N-1 -> Index<=0, go DONE; else Index<=Index+1, go WAIT_SPACE.
REQ-023 DONE: FRAME_DONE=1 for this cycle; next IDLE.
REQ-024 Outputs READ_ACK, BUFF_RD_EN, BUFF_RD_ADDR, FIFO_OUT_WE, FIFO_OUT_DATA, FRAME_DONE SHALL be decoded from state only (Moore); 0 in every state not listed above for that output.
REQ-025 Readout order SHALL be linear index 0..N-1 of the latched bank, giving column-major output of the row-major written matrix.
REQ-026 READ_START asserted while BUSY SHALL be ignored (no ACK) until IDLE is re-entered; it is then granted from IDLE, at the earliest one cycle after DONE.
REQ-027 Bank_Reg SHALL not change between ACK and DONE regardless of PING_PONG_FLAG toggling.
REQ-028 Index SHALL be AW bits and never exceed N-1; non-power-of-two N wraps at N-1, not 2^AW-1.
REQ-029 FIFO_OUT_FULL is sampled only in WAIT_SPACE; a FIFO_OUT_FULL rise during RD_REQ/RD_CAPTURE/WR_FIFO SHALL not abort the in-flight bit (FIFO keeps one slot of headroom).
REQ-030 Per-bit throughput SHALL be 4 cycles when FIFO_OUT_FULL=0; frame latency READ_START to FRAME_DONE = 2 + 4*N cycles.

Reset
REQ-031 RESET=1 SHALL force IDLE, Index=0, Bank_Reg=0, Data_Reg=0 at the next edge, from any state including mid-frame.
REQ-032 During and immediately after reset all outputs SHALL be 0; the partially read frame is discarded, not resumed.

Verification
REQ-033 Reset, then READ_START=1, FLAG=0, FULL=0 -> READ_ACK one cycle 1 cycle later; addresses 0..69 bank 0; 70 FIFO_OUT_WE pulses; FRAME_DONE at cycle 282.
REQ-034 Buffer preloaded with k at index k parity pattern, FLAG=1 -> BUFF_RD_ADDR MSB=1 for all reads; FIFO_OUT_DATA sequence matches preload order 0..69.
REQ-035 FIFO_OUT_FULL held 1 for 20 cycles after bit 5 -> FSM stalls in WAIT_SPACE, no RD_EN/WE, bit 6 from index 6 after release, no loss or duplication.
REQ-036 Second READ_START raised at bit 30 of frame 1 -> no ACK until DONE; ACK issued in IDLE right after; frame 2 uses FLAG value present at that grant.
REQ-037 RESET pulsed at bit 40 -> all outputs 0 next cycle; new READ_START -> readout restarts at index 0.
REQ-038 ROW_NUMBER=3, COL_NUMBER=3 (N=9, AW=4) -> Index wraps after 8; exactly 9 writes per frame.

Source files
------------

// File: rtl/interleaver_read_scheduler_if.sv
// Signal bundle between the interleaver read scheduler, the ping-pong frame buffer
// and the output FIFO. The scheduler uses the master modport and its environment uses slave.
interface interleaver_read_scheduler_if #(
  parameter int AW = 7
);
  // Handshakes: READ_START stays high until a one-cycle READ_ACK grants it. BUFF_RD_DATA
  // is valid the cycle after BUFF_RD_EN. A FIFO_OUT_WE write is only started after
  // FIFO_OUT_FULL was seen low, and the FIFO keeps one slot of headroom for a bit in flight.
  logic          READ_START;
  logic          READ_ACK;
  logic          PING_PONG_FLAG;
  logic [AW:0]   BUFF_RD_ADDR;
  logic          BUFF_RD_EN;
  logic          BUFF_RD_DATA;
  logic          FIFO_OUT_DATA;
  logic          FIFO_OUT_WE;
  logic          FIFO_OUT_FULL;
  logic          BUSY;
  logic          FRAME_DONE;

  modport master (
    input  READ_START, PING_PONG_FLAG, BUFF_RD_DATA, FIFO_OUT_FULL,
    output READ_ACK, BUFF_RD_ADDR, BUFF_RD_EN, FIFO_OUT_DATA, FIFO_OUT_WE, BUSY, FRAME_DONE
  );

  modport slave (
    output READ_START, PING_PONG_FLAG, BUFF_RD_DATA, FIFO_OUT_FULL,
    input  READ_ACK, BUFF_RD_ADDR, BUFF_RD_EN, FIFO_OUT_DATA, FIFO_OUT_WE, BUSY, FRAME_DONE
  );
endinterface

// File: rtl/interleaver_read_scheduler.sv
// Reads one filled ping-pong bank in linear index order, which produces column-major output
// of the row-major written matrix. It moves one bit into the output FIFO every 4 cycles.
module interleaver_read_scheduler #(
  parameter int ROW_NUMBER = 10,
  parameter int COL_NUMBER = 7
) (
  input  logic                           CLK,
  input  logic                           RESET,
  interleaver_read_scheduler_if.master   bus,
  output logic [2:0]                     dbg_state
);
  localparam int N  = ROW_NUMBER * COL_NUMBER;
  localparam int AW = (N > 1) ? $clog2(N) : 1;
  localparam logic [AW-1:0] LAST_INDEX = AW'(N - 1);

  localparam logic [2:0] S_IDLE       = 3'd0;
  localparam logic [2:0] S_ACK        = 3'd1;
  localparam logic [2:0] S_WAIT_SPACE = 3'd2;
  localparam logic [2:0] S_RD_REQ     = 3'd3;
  localparam logic [2:0] S_RD_CAPTURE = 3'd4;
  localparam logic [2:0] S_WR_FIFO    = 3'd5;
  localparam logic [2:0] S_DONE       = 3'd6;

  logic [2:0]    state;
  logic [2:0]    state_nxt;
  logic          bank_reg;
  logic [AW-1:0] index;
  logic          data_reg;
  logic          last_bit;

  assign last_bit  = (index == LAST_INDEX);
  assign dbg_state = state;

  always_ff @(posedge CLK) begin
    if (RESET) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = S_IDLE;
    case (state)
      S_IDLE:       state_nxt = bus.READ_START ? S_ACK : S_IDLE;
      S_ACK:        state_nxt = S_WAIT_SPACE;
      S_WAIT_SPACE: state_nxt = bus.FIFO_OUT_FULL ? S_WAIT_SPACE : S_RD_REQ;
      S_RD_REQ:     state_nxt = S_RD_CAPTURE;
      S_RD_CAPTURE: state_nxt = S_WR_FIFO;
      S_WR_FIFO:    state_nxt = last_bit ? S_DONE : S_WAIT_SPACE;
      S_DONE:       state_nxt = S_IDLE;
      default:      state_nxt = S_IDLE;
    endcase
  end

  // Bank is latched only at grant, so flag toggles from the writer cannot disturb a frame.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      bank_reg <= 1'b0;
      index    <= '0;
      data_reg <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.READ_START) begin
            bank_reg <= bus.PING_PONG_FLAG;
            index    <= '0;
          end
        end
        S_RD_CAPTURE: data_reg <= bus.BUFF_RD_DATA;
        S_WR_FIFO:    index    <= last_bit ? '0 : index + AW'(1);
        default: ;
      endcase
    end
  end

  always_comb begin
    bus.READ_ACK      = 1'b0;
    bus.BUFF_RD_EN    = 1'b0;
    bus.BUFF_RD_ADDR  = '0;
    bus.FIFO_OUT_WE   = 1'b0;
    bus.FIFO_OUT_DATA = 1'b0;
    bus.FRAME_DONE    = 1'b0;
    bus.BUSY          = (state != S_IDLE);
    case (state)
      S_ACK:    bus.READ_ACK = 1'b1;
      S_RD_REQ: begin
        bus.BUFF_RD_EN   = 1'b1;
        bus.BUFF_RD_ADDR = {bank_reg, index};
      end
      S_WR_FIFO: begin
        bus.FIFO_OUT_WE   = 1'b1;
        bus.FIFO_OUT_DATA = data_reg;
      end
      S_DONE:   bus.FRAME_DONE = 1'b1;
      default: ;
    endcase
  end
endmodule

// File: tb/tb_interleaver_read_scheduler.sv
// Directed bench for interleaver_read_scheduler: a 10x7 instance and a 3x3 instance,
// behavioural buffer models and an address/data scoreboard.
module tb_interleaver_read_scheduler;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  interleaver_read_scheduler_if #(.AW(7)) bus_a ();
  interleaver_read_scheduler_if #(.AW(4)) bus_b ();
  logic [2:0] dbg_a;
  logic [2:0] dbg_b;

  interleaver_read_scheduler #(.ROW_NUMBER(10), .COL_NUMBER(7)) dut_a (
    .CLK(clk), .RESET(rst), .bus(bus_a.master), .dbg_state(dbg_a)
  );
  interleaver_read_scheduler #(.ROW_NUMBER(3), .COL_NUMBER(3)) dut_b (
    .CLK(clk), .RESET(rst), .bus(bus_b.master), .dbg_state(dbg_b)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Buffer content: bank 1 holds the parity of k, bank 0 holds (k mod 3 == 0).
  function automatic logic pat(input logic bank, input int k);
    logic [6:0] kk;
    kk = k[6:0];
    return bank ? ^kk : (k % 3 == 0);
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      bus_a.BUFF_RD_DATA <= 1'b0;
      bus_b.BUFF_RD_DATA <= 1'b0;
    end else begin
      if (bus_a.BUFF_RD_EN) bus_a.BUFF_RD_DATA <= pat(bus_a.BUFF_RD_ADDR[7], int'(bus_a.BUFF_RD_ADDR[6:0]));
      if (bus_b.BUFF_RD_EN) bus_b.BUFF_RD_DATA <= pat(bus_b.BUFF_RD_ADDR[4], int'(bus_b.BUFF_RD_ADDR[3:0]));
    end
  end

  logic [7:0] exp_addr_a[$];
  logic [7:0] exp_data_a[$];
  logic [7:0] exp_addr_b[$];
  logic [7:0] exp_data_b[$];
  int ack_cnt_a = 0, rd_cnt_a = 0, we_cnt_a = 0, done_cnt_a = 0, ack_cyc_a = 0, done_cyc_a = 0;
  int ack_cnt_b = 0, we_cnt_b = 0, done_cnt_b = 0, ack_cyc_b = 0, done_cyc_b = 0;
  int start_cyc_a = 0, start_cyc_b = 0;

  always @(negedge clk) begin
    if (bus_a.READ_ACK) begin ack_cnt_a++; ack_cyc_a = cyc; end
    if (bus_a.FRAME_DONE) begin done_cnt_a++; done_cyc_a = cyc; end
    if (bus_a.BUFF_RD_EN) begin
      rd_cnt_a++;
      if (exp_addr_a.size() == 0) check("a_rd_unexpected", 1, 0);
      else check("a_rd_addr", {24'b0, bus_a.BUFF_RD_ADDR}, {24'b0, exp_addr_a.pop_front()});
    end
    if (bus_a.FIFO_OUT_WE) begin
      we_cnt_a++;
      if (exp_data_a.size() == 0) check("a_we_unexpected", 1, 0);
      else check("a_we_data", {31'b0, bus_a.FIFO_OUT_DATA}, {24'b0, exp_data_a.pop_front()});
    end
  end

  always @(negedge clk) begin
    if (bus_b.READ_ACK) begin ack_cnt_b++; ack_cyc_b = cyc; end
    if (bus_b.FRAME_DONE) begin done_cnt_b++; done_cyc_b = cyc; end
    if (bus_b.BUFF_RD_EN) begin
      if (exp_addr_b.size() == 0) check("b_rd_unexpected", 1, 0);
      else check("b_rd_addr", {27'b0, bus_b.BUFF_RD_ADDR}, {24'b0, exp_addr_b.pop_front()});
    end
    if (bus_b.FIFO_OUT_WE) begin
      we_cnt_b++;
      if (exp_data_b.size() == 0) check("b_we_unexpected", 1, 0);
      else check("b_we_data", {31'b0, bus_b.FIFO_OUT_DATA}, {24'b0, exp_data_b.pop_front()});
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic load_exp_a(input logic bank);
    for (int k = 0; k < 70; k++) begin
      exp_addr_a.push_back({bank, 7'(k)});
      exp_data_a.push_back({7'b0, pat(bank, k)});
    end
  endtask

  task automatic load_exp_b(input logic bank);
    for (int k = 0; k < 9; k++) begin
      exp_addr_b.push_back({3'b0, bank, 4'(k)});
      exp_data_b.push_back({7'b0, pat(bank, k)});
    end
  endtask

  task automatic expect_quiet_a(input string tag);
    check({tag, "_ack"},   {31'b0, bus_a.READ_ACK}, 0);
    check({tag, "_rd_en"}, {31'b0, bus_a.BUFF_RD_EN}, 0);
    check({tag, "_addr"},  {24'b0, bus_a.BUFF_RD_ADDR}, 0);
    check({tag, "_we"},    {31'b0, bus_a.FIFO_OUT_WE}, 0);
    check({tag, "_data"},  {31'b0, bus_a.FIFO_OUT_DATA}, 0);
    check({tag, "_busy"},  {31'b0, bus_a.BUSY}, 0);
    check({tag, "_done"},  {31'b0, bus_a.FRAME_DONE}, 0);
    check({tag, "_state"}, {29'b0, dbg_a}, 0);
  endtask

  task automatic start_a(input logic flag);
    int a0;
    int t;
    load_exp_a(flag);
    bus_a.PING_PONG_FLAG = flag;
    bus_a.READ_START = 1'b1;
    start_cyc_a = cyc;
    a0 = ack_cnt_a;
    t = 0;
    while (ack_cnt_a == a0 && t < 10) begin tick(); t++; end
    check("a_ack_seen", ack_cnt_a - a0, 1);
    check("a_ack_latency", ack_cyc_a - start_cyc_a, 1);
    bus_a.READ_START = 1'b0;
  endtask

  task automatic start_b(input logic flag);
    int a0;
    int t;
    load_exp_b(flag);
    bus_b.PING_PONG_FLAG = flag;
    bus_b.READ_START = 1'b1;
    start_cyc_b = cyc;
    a0 = ack_cnt_b;
    t = 0;
    while (ack_cnt_b == a0 && t < 10) begin tick(); t++; end
    check("b_ack_seen", ack_cnt_b - a0, 1);
    check("b_ack_latency", ack_cyc_b - start_cyc_b, 1);
    bus_b.READ_START = 1'b0;
  endtask

  task automatic wait_done_a(input int budget);
    int d0;
    int t;
    d0 = done_cnt_a;
    t = 0;
    while (done_cnt_a == d0 && t < budget) begin tick(); t++; end
    check("a_frame_done_seen", done_cnt_a - d0, 1);
  endtask

  task automatic wait_done_b(input int budget);
    int d0;
    int t;
    d0 = done_cnt_b;
    t = 0;
    while (done_cnt_b == d0 && t < budget) begin tick(); t++; end
    check("b_frame_done_seen", done_cnt_b - d0, 1);
  endtask

  task automatic wait_we_a(input int target, input int budget);
    int t;
    t = 0;
    while (we_cnt_a < target && t < budget) begin tick(); t++; end
    check("a_we_reached", {31'b0, we_cnt_a >= target}, 1);
  endtask

  task automatic wait_rd_a(input int target, input int budget);
    int t;
    t = 0;
    while (rd_cnt_a < target && t < budget) begin tick(); t++; end
    check("a_rd_reached", {31'b0, rd_cnt_a >= target}, 1);
  endtask

  task automatic frame_end_a(input string tag);
    check({tag, "_addr_left"}, exp_addr_a.size(), 0);
    check({tag, "_data_left"}, exp_data_a.size(), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int base;
    int rd0;
    int we0;
    int a1;
    int d0;
    int t;
    bus_a.READ_START = 1'b0; bus_a.PING_PONG_FLAG = 1'b0; bus_a.FIFO_OUT_FULL = 1'b0;
    bus_b.READ_START = 1'b0; bus_b.PING_PONG_FLAG = 1'b0; bus_b.FIFO_OUT_FULL = 1'b0;

    // Reset: outputs quiet during and after reset.
    rst = 1'b1;
    repeat (3) tick();
    expect_quiet_a("rst_during");
    check("b_rst_busy", {31'b0, bus_b.BUSY}, 0);
    rst = 1'b0;
    tick();
    expect_quiet_a("rst_after");
    check("b_rst_state", {29'b0, dbg_b}, 0);

    // Frame from bank 0, unthrottled.
    base = we_cnt_a;
    start_a(1'b0);
    check("t1_busy", {31'b0, bus_a.BUSY}, 1);
    wait_done_a(400);
    check("t1_latency", done_cyc_a - start_cyc_a, 282);
    check("t1_writes", we_cnt_a - base, 70);
    frame_end_a("t1");
    tick();
    check("t1_idle_busy", {31'b0, bus_a.BUSY}, 0);
    check("t1_one_ack", ack_cnt_a, 1);

    // Frame from bank 1, parity pattern.
    tick();
    base = we_cnt_a;
    start_a(1'b1);
    wait_done_a(400);
    check("t2_latency", done_cyc_a - start_cyc_a, 282);
    check("t2_writes", we_cnt_a - base, 70);
    frame_end_a("t2");
    tick();

    // FIFO full after bit 5, then a full rise while bit 10 is in flight.
    base = we_cnt_a;
    start_a(1'b0);
    wait_we_a(base + 6, 100);
    bus_a.FIFO_OUT_FULL = 1'b1;
    rd0 = rd_cnt_a;
    we0 = we_cnt_a;
    repeat (20) tick();
    check("t3_stall_state", {29'b0, dbg_a}, 2);
    check("t3_stall_rd", rd_cnt_a - rd0, 0);
    check("t3_stall_we", we_cnt_a - we0, 0);
    bus_a.FIFO_OUT_FULL = 1'b0;
    wait_rd_a(rd0 + 5, 100);
    bus_a.FIFO_OUT_FULL = 1'b1;
    we0 = we_cnt_a;
    tick();
    tick();
    check("t3_inflight_we", we_cnt_a - we0, 1);
    repeat (3) tick();
    check("t3_restall_rd", rd_cnt_a - rd0, 5);
    bus_a.FIFO_OUT_FULL = 1'b0;
    wait_done_a(400);
    check("t3_writes", we_cnt_a - base, 70);
    frame_end_a("t3");
    tick();

    // Second request raised at bit 30, flag toggled while frames run.
    base = we_cnt_a;
    start_a(1'b0);
    wait_we_a(base + 30, 200);
    a1 = ack_cnt_a;
    bus_a.PING_PONG_FLAG = 1'b1;
    bus_a.READ_START = 1'b1;
    load_exp_a(1'b1);
    wait_done_a(400);
    check("t4_no_early_ack", ack_cnt_a - a1, 0);
    t = 0;
    while (ack_cnt_a == a1 && t < 10) begin tick(); t++; end
    check("t4_ack_after_done", ack_cyc_a - done_cyc_a, 2);
    bus_a.READ_START = 1'b0;
    bus_a.PING_PONG_FLAG = 1'b0;
    wait_done_a(400);
    check("t4_writes", we_cnt_a - base, 140);
    frame_end_a("t4");
    tick();

    // Reset in the middle of a frame discards it.
    base = we_cnt_a;
    start_a(1'b1);
    wait_we_a(base + 40, 200);
    rst = 1'b1;
    tick();
    expect_quiet_a("t5_rst");
    rst = 1'b0;
    exp_addr_a.delete();
    exp_data_a.delete();
    tick();
    expect_quiet_a("t5_post");
    rd0 = rd_cnt_a;
    d0 = done_cnt_a;
    repeat (5) tick();
    check("t5_no_resume", rd_cnt_a - rd0, 0);
    check("t5_no_done", done_cnt_a - d0, 0);
    start_a(1'b0);
    wait_done_a(400);
    check("t5_latency", done_cyc_a - start_cyc_a, 282);
    frame_end_a("t5");

    // 3x3 instance: index wraps after 8, two back-to-back frames.
    tick();
    start_b(1'b0);
    wait_done_b(100);
    check("t6_latency", done_cyc_b - start_cyc_b, 38);
    check("t6_writes", we_cnt_b, 9);
    tick();
    start_b(1'b1);
    wait_done_b(100);
    check("t6_writes2", we_cnt_b, 18);
    check("t6_addr_left", exp_addr_b.size(), 0);
    check("t6_data_left", exp_data_b.size(), 0);
    tick();
    check("t6_idle", {29'b0, dbg_b}, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
